// File: rtl/det_win_counter.sv
// Windowed match counter for the serial 1101 detector: counts det_pulse events over
// WIN_LEN enabled cycles and publishes a count/sat/lost report over valid/ready.
module det_win_counter #(
    parameter int unsigned WIN_LEN = 16,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_pulse,
    input  logic             en,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_lost
);

    localparam int unsigned WCNT_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        R_EMPTY = 1'b0,
        R_FULL  = 1'b1
    } rpt_state_e;

    rpt_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  ev_cnt_q, ev_cnt_d;
    logic              ev_sat_q, ev_sat_d;
    logic              rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
    logic              rpt_sat_q, rpt_sat_d;
    logic              rpt_lost_q, rpt_lost_d;

    logic              close_c;
    logic              at_max_c;
    logic [CNT_W-1:0]  fin_count_c;
    logic              fin_sat_c;

    // Window close and the closing cycle's saturating final tally
    always_comb begin
        close_c     = en && (wcnt_q == WCNT_LAST);
        at_max_c    = (ev_cnt_q == CNT_MAX);
        fin_count_c = ev_cnt_q;
        fin_sat_c   = ev_sat_q;
        if (det_pulse) begin
            if (at_max_c) begin
                fin_sat_c = 1'b1;
            end else begin
                fin_count_c = ev_cnt_q + CNT_W'(1);
            end
        end
    end

    // Window and event counters; disabled cycles abort the window in progress
    always_comb begin
        wcnt_d   = wcnt_q;
        ev_cnt_d = ev_cnt_q;
        ev_sat_d = ev_sat_q;
        if (!en || close_c) begin
            wcnt_d   = '0;
            ev_cnt_d = '0;
            ev_sat_d = 1'b0;
        end else begin
            wcnt_d   = wcnt_q + WCNT_W'(1);
            ev_cnt_d = fin_count_c;
            ev_sat_d = fin_sat_c;
        end
    end

    // Report FSM: a close while a report is still unaccepted marks the new one lost
    always_comb begin
        state_d     = state_q;
        rpt_count_d = rpt_count_q;
        rpt_sat_d   = rpt_sat_q;
        rpt_lost_d  = rpt_lost_q;
        unique case (state_q)
            R_EMPTY: begin
                if (close_c) begin
                    state_d     = R_FULL;
                    rpt_count_d = fin_count_c;
                    rpt_sat_d   = fin_sat_c;
                    rpt_lost_d  = 1'b0;
                end
            end
            R_FULL: begin
                if (close_c) begin
                    rpt_count_d = fin_count_c;
                    rpt_sat_d   = fin_sat_c;
                    rpt_lost_d  = !rpt_ready;
                end else if (rpt_ready) begin
                    state_d     = R_EMPTY;
                    rpt_count_d = '0;
                    rpt_sat_d   = 1'b0;
                    rpt_lost_d  = 1'b0;
                end
            end
            default: state_d = R_EMPTY;
        endcase
        rpt_valid_d = (state_d == R_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= R_EMPTY;
            wcnt_q      <= '0;
            ev_cnt_q    <= '0;
            ev_sat_q    <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_count_q <= '0;
            rpt_sat_q   <= 1'b0;
            rpt_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ev_cnt_q    <= ev_cnt_d;
            ev_sat_q    <= ev_sat_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_count_q <= rpt_count_d;
            rpt_sat_q   <= rpt_sat_d;
            rpt_lost_q  <= rpt_lost_d;
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign rpt_count = rpt_count_q;
    assign rpt_sat   = rpt_sat_q;
    assign rpt_lost  = rpt_lost_q;

endmodule

// File: tb/tb_det_win_counter.sv
// Directed bench for det_win_counter: window counting, saturation, back-pressure,
// enable drop, async reset, and a live 1101 detector feeding det_pulse.
module tb_det_win_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       det_pulse_tb;
    logic       rpt_ready;
    logic       rpt_valid;
    logic [3:0] rpt_count;
    logic       rpt_sat;
    logic       rpt_lost;

    logic       use_det;
    logic       din;
    logic [2:0] hist;
    logic       det_y;
    logic       det_in;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Reference 1101 Moore detector with registered, overlapping-match output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= 3'b000;
            det_y <= 1'b0;
        end else begin
            det_y <= (hist == 3'b110) && din;
            hist  <= {hist[1:0], din};
        end
    end

    assign det_in = use_det ? det_y : det_pulse_tb;

    det_win_counter #(.WIN_LEN(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_pulse (det_in),
        .en        (en),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_count (rpt_count),
        .rpt_sat   (rpt_sat),
        .rpt_lost  (rpt_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_rpt(input string tag, input logic v, input logic [3:0] c,
                           input logic s, input logic l);
        chk({tag, "_valid"}, 32'(rpt_valid), 32'(v));
        chk({tag, "_count"}, 32'(rpt_count), 32'(c));
        chk({tag, "_sat"},   32'(rpt_sat),   32'(s));
        chk({tag, "_lost"},  32'(rpt_lost),  32'(l));
    endtask

    // One 16-cycle window; outputs must hold (ev, ec, el) after edges 1..15
    task automatic win(input string tag, input logic [15:0] pm, input logic [15:0] rm,
                       input logic ev, input logic [3:0] ec, input logic el);
        for (int k = 0; k < 16; k++) begin
            det_pulse_tb = pm[k];
            rpt_ready    = rm[k];
            tick();
            if (k < 15) begin
                chk({tag, "_mid_valid"}, 32'(rpt_valid), 32'(ev));
                chk({tag, "_mid_count"}, 32'(rpt_count), 32'(ec));
                chk({tag, "_mid_lost"},  32'(rpt_lost),  32'(el));
            end
        end
        det_pulse_tb = 1'b0;
        rpt_ready    = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        int         pi;
        int         exp_cnt;
        pat          = 7'b1101101;
        pi           = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        det_pulse_tb = 1'b0;
        rpt_ready    = 1'b0;
        use_det      = 1'b0;
        din          = 1'b0;
        tick();
        tick();
        chk_rpt("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Basic count: pulses at wcnt 3, 7, 15
        win("t1", 16'h8088, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        chk_rpt("t1_rpt", 1'b1, 4'd3, 1'b0, 1'b0);

        // Saturation, then a 2-pulse window
        win("t2a", 16'hFFFF, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        chk_rpt("t2a_rpt", 1'b1, 4'd15, 1'b1, 1'b0);
        win("t2b", 16'h0012, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        chk_rpt("t2b_rpt", 1'b1, 4'd2, 1'b0, 1'b0);

        // Back-pressure across two closes
        win("t3a", 16'h0155, 16'h0001, 1'b0, 4'd0, 1'b0);
        chk_rpt("t3a_rpt", 1'b1, 4'd5, 1'b0, 1'b0);
        win("t3b", 16'h0400, 16'h0000, 1'b1, 4'd5, 1'b0);
        chk_rpt("t3b_rpt", 1'b1, 4'd1, 1'b0, 1'b1);
        win("t3c", 16'h0003, 16'h0001, 1'b0, 4'd0, 1'b0);
        chk_rpt("t3c_rpt", 1'b1, 4'd2, 1'b0, 1'b0);

        // Accept coinciding with close
        win("t4", 16'h0007, 16'h8000, 1'b1, 4'd2, 1'b0);
        chk_rpt("t4_rpt", 1'b1, 4'd3, 1'b0, 1'b0);
        win("t4e", 16'h0000, 16'h0001, 1'b0, 4'd0, 1'b0);
        chk_rpt("t4e_rpt", 1'b1, 4'd0, 1'b0, 1'b0);

        // Enable drop aborts the window in progress
        for (int k = 0; k < 9; k++) begin
            det_pulse_tb = (k == 2) || (k == 5);
            rpt_ready    = (k == 0);
            tick();
        end
        chk("t5_pre_valid", 32'(rpt_valid), 32'd0);
        en           = 1'b0;
        det_pulse_tb = 1'b1;
        rpt_ready    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_dis_valid", 32'(rpt_valid), 32'd0);
        end
        en           = 1'b1;
        det_pulse_tb = 1'b0;
        win("t5", 16'h1212, 16'h0000, 1'b0, 4'd0, 1'b0);
        chk_rpt("t5_rpt", 1'b1, 4'd4, 1'b0, 1'b0);

        // Async reset mid-window with a report pending
        for (int k = 0; k < 10; k++) tick();
        chk_rpt("t6_pend", 1'b1, 4'd4, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rpt("t6_async", 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        chk_rpt("t6_rel", 1'b0, 4'd0, 1'b0, 1'b0);
        win("t6", 16'h0001, 16'h0000, 1'b0, 4'd0, 1'b0);
        chk_rpt("t6_rpt", 1'b1, 4'd1, 1'b0, 1'b0);

        // Live detector on a repeating 1101101 stream
        use_det = 1'b1;
        for (int w = 0; w < 3; w++) begin
            exp_cnt = 0;
            for (int k = 0; k < 16; k++) begin
                din       = pat[6 - (pi % 7)];
                pi++;
                rpt_ready = 1'b1;
                exp_cnt  += int'(det_y);
                tick();
            end
            chk("det_valid", 32'(rpt_valid), 32'd1);
            chk("det_count", 32'(rpt_count), 32'(exp_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
